current_sample_seq: RTL and testbench

CURRENT_SAMPLE_SEQ -- requirements
Module: current_sample_seq

---
 rtl/current_sample_seq.sv | 133 +++++++++++++
 tb/tb_current_sample_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/current_sample_seq.sv
// rtl/current_sample_seq.sv - current sensor sampling FSM with offset correction and 5.22 scaling
// Optional offset calibration is compiled in with SAMPLE_CALI_EN.
`timescale 1ns/1ps
module current_sample_seq #(
   parameter logic [7:0]         SENSOR_REG = 8'h01,
   parameter int unsigned        TIMEOUT    = 1024,
   parameter logic signed [26:0] SCALE_Q22  = 27'sd4194
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_tick,
   input  logic        cali,
   output logic        rd_req,
   output logic [7:0]  rd_reg,
   input  logic        rd_done,
   input  logic [15:0] rd_data,
   input  logic        rd_err,
   output logic [26:0] data_out,
   output logic        data_valid,
   output logic        cali_busy,
   output logic [7:0]  err_cnt,
   output logic [7:0]  ovr_cnt
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, CONV, OUT} state_t;

   state_t               state, state_nxt;
   logic [TW-1:0]        timer;
   logic signed [15:0]   raw_q;
   logic signed [16:0]   offset;
   logic signed [16:0]   corrected;
   logic signed [43:0]   product;
   logic [26:0]          sat;
   logic                 accept;
   logic                 timeout_hit;
   logic                 err_evt;

   assign rd_req      = (state == REQ);
   assign rd_reg      = SENSOR_REG;
   assign data_valid  = (state == OUT);
   assign accept      = (state == REQ) && rd_done && !rd_err;
   assign timeout_hit = (state == REQ) && !rd_done && (timer == TW'(TIMEOUT - 1));
   assign err_evt     = ((state == REQ) && rd_done && rd_err) || timeout_hit;

   // raw and offset are both 16-bit ranged, so their difference always fits 17 bits
   assign corrected = {raw_q[15], raw_q} - offset;
   assign product   = 44'(corrected) * 44'(SCALE_Q22);

   always_comb begin
      sat = product[26:0];
      if (!((&product[43:26]) || !(|product[43:26])))
         sat = product[43] ? 27'h4000000 : 27'h3FFFFFF;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (sample_tick) state_nxt = REQ;
         REQ: begin
            if (rd_done)          state_nxt = rd_err ? IDLE : CONV;
            else if (timeout_hit) state_nxt = IDLE;
         end
         // calibration samples never reach the integrator
         CONV:    state_nxt = cali_busy ? IDLE : OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer    <= '0;
         raw_q    <= '0;
         data_out <= '0;
         err_cnt  <= '0;
         ovr_cnt  <= '0;
      end else begin
         timer <= (state == REQ) ? timer + TW'(1) : '0;
         if (accept) raw_q <= rd_data;
         if (state == CONV && !cali_busy) data_out <= sat;
         if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (sample_tick && state != IDLE && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
      end
   end

`ifdef SAMPLE_CALI_EN
   logic signed [20:0] cal_sum;
   logic signed [20:0] cal_sum_nxt;
   logic [3:0]         cal_cnt;
   logic               cal_busy_q;

   assign cal_sum_nxt = cal_sum + 21'(raw_q);
   assign cali_busy   = cal_busy_q;

   // a cali strobe always wins, so a restart discards the partial sum
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cal_sum    <= '0;
         cal_cnt    <= '0;
         cal_busy_q <= 1'b0;
         offset     <= '0;
      end else if (cali) begin
         cal_sum    <= '0;
         cal_cnt    <= '0;
         cal_busy_q <= 1'b1;
      end else if (state == CONV && cal_busy_q) begin
         if (cal_cnt == 4'd15) begin
            offset     <= cal_sum_nxt[20:4];
            cal_sum    <= '0;
            cal_cnt    <= '0;
            cal_busy_q <= 1'b0;
         end else begin
            cal_sum <= cal_sum_nxt;
            cal_cnt <= cal_cnt + 4'd1;
         end
      end
   end
`else
   logic unused_cali;

   assign unused_cali = cali;
   assign offset      = '0;
   assign cali_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_current_sample_seq.sv
// tb/tb_current_sample_seq.sv - scoreboard bench for current_sample_seq
`timescale 1ns/1ps
module tb_current_sample_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_tick = 1'b0;
   logic        cali = 1'b0;
   logic        rd_req;
   logic [7:0]  rd_reg;
   logic        rd_done = 1'b0;
   logic [15:0] rd_data = '0;
   logic        rd_err = 1'b0;
   logic [26:0] data_out;
   logic        data_valid;
   logic        cali_busy;
   logic [7:0]  err_cnt;
   logic [7:0]  ovr_cnt;

   int total = 0;
   int bad = 0;
   int dv_count = 0;
   int exp_offset = 0;
   logic [26:0] exp_q[$];

   current_sample_seq dut (
      .clk(clk), .reset(reset), .sample_tick(sample_tick), .cali(cali),
      .rd_req(rd_req), .rd_reg(rd_reg), .rd_done(rd_done), .rd_data(rd_data),
      .rd_err(rd_err), .data_out(data_out), .data_valid(data_valid),
      .cali_busy(cali_busy), .err_cnt(err_cnt), .ovr_cnt(ovr_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         logic [26:0] e;
         dv_count++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid data_out=%0h expected no valid", data_out);
         end else begin
            e = exp_q.pop_front();
            if (data_out !== e) begin
               bad++;
               $display("FAIL data_out got=%0h exp=%0h", data_out, e);
            end
         end
      end
   end

   function automatic logic [26:0] model(input int raw, input int off);
      longint v;
      logic [63:0] vb;
      v = (longint'(raw) - longint'(off)) * 64'sd4194;
      if (v > 64'sd67108863)  return 27'h3FFFFFF;
      if (v < -64'sd67108864) return 27'h4000000;
      vb = v;
      return vb[26:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input int raw, input logic err, input logic expect_valid);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL rd_req_rise got=%0b exp=1", rd_req); end
      rd_data = 16'(raw);
      rd_err  = err;
      rd_done = 1'b1;
      if (expect_valid) exp_q.push_back(model(raw, exp_offset));
      step();
      rd_done = 1'b0;
      rd_err  = 1'b0;
      total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL rd_req_drop got=%0b exp=0", rd_req); end
      step();
      total++; if (data_valid !== expect_valid) begin bad++; $display("FAIL valid_latency got=%0b exp=%0b", data_valid, expect_valid); end
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      total++; if (rd_req !== 1'b0)    begin bad++; $display("FAIL rst_rd_req got=%0b exp=0", rd_req); end
      total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", data_valid); end
      total++; if (data_out !== 27'd0) begin bad++; $display("FAIL rst_data got=%0h exp=0", data_out); end
      total++; if (err_cnt !== 8'd0)   begin bad++; $display("FAIL rst_err got=%0d exp=0", err_cnt); end
      total++; if (ovr_cnt !== 8'd0)   begin bad++; $display("FAIL rst_ovr got=%0d exp=0", ovr_cnt); end
      total++; if (cali_busy !== 1'b0) begin bad++; $display("FAIL rst_cali got=%0b exp=0", cali_busy); end
      total++; if (rd_reg !== 8'h01)   begin bad++; $display("FAIL rd_reg got=%0h exp=01", rd_reg); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      do_read(1000, 1'b0, 1'b1);
      do_read(-5, 1'b0, 1'b1);
      do_read(0, 1'b0, 1'b1);
   endtask

   task automatic test_saturation();
      do_read(32767, 1'b0, 1'b1);
      do_read(-32768, 1'b0, 1'b1);
      do_read(16000, 1'b0, 1'b1);
      do_read(-16000, 1'b0, 1'b1);
   endtask

   task automatic test_errors();
      int n0;
      int n;
      n0 = dv_count;
      do_read(1234, 1'b1, 1'b0);
      total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL err_after_nack got=%0d exp=1", err_cnt); end
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      n = 0;
      while (rd_req === 1'b1 && n < 1030) begin step(); n++; end
      total++; if (n !== 1024) begin bad++; $display("FAIL timeout_len got=%0d exp=1024", n); end
      total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL err_after_timeout got=%0d exp=2", err_cnt); end
      total++; if (dv_count !== n0) begin bad++; $display("FAIL err_no_valid got=%0d exp=%0d", dv_count, n0); end
      do_read(1000, 1'b0, 1'b1);
   endtask

   task automatic test_overrun();
      int n0;
      n0 = dv_count;
      rd_data = 16'd77;
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
      step();
      total++; if (rd_req !== 1'b0 || dv_count !== n0) begin bad++; $display("FAIL idle_rd_done rd_req=%0b dv=%0d exp 0/%0d", rd_req, dv_count, n0); end
      sample_tick = 1'b1;
      step();
      step();
      sample_tick = 1'b0;
      rd_data = 16'd1000;
      rd_done = 1'b1;
      exp_q.push_back(model(1000, exp_offset));
      step();
      rd_done = 1'b0;
      step();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      total++; if (ovr_cnt !== 8'd2) begin bad++; $display("FAIL ovr_cnt got=%0d exp=2", ovr_cnt); end
      total++; if (dv_count !== n0 + 1) begin bad++; $display("FAIL ovr_valids got=%0d exp=%0d", dv_count, n0 + 1); end
      total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL ovr_dropped_tick rd_req=%0b exp=0", rd_req); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         int raw;
         raw = int'($urandom_range(6000)) - 3000;
         do_read(raw, 1'b0, 1'b1);
      end
   endtask

   task automatic test_cali();
`ifdef SAMPLE_CALI_EN
      int n0;
      cali = 1'b1;
      step();
      cali = 1'b0;
      total++; if (cali_busy !== 1'b1) begin bad++; $display("FAIL cali_start got=%0b exp=1", cali_busy); end
      for (int i = 0; i < 3; i++) do_read(500, 1'b0, 1'b0);
      cali = 1'b1;
      step();
      cali = 1'b0;
      n0 = dv_count;
      for (int i = 0; i < 15; i++) do_read(20, 1'b0, 1'b0);
      total++; if (cali_busy !== 1'b1) begin bad++; $display("FAIL cali_busy_15 got=%0b exp=1", cali_busy); end
      do_read(20, 1'b0, 1'b0);
      total++; if (cali_busy !== 1'b0) begin bad++; $display("FAIL cali_done got=%0b exp=0", cali_busy); end
      total++; if (dv_count !== n0) begin bad++; $display("FAIL cali_no_valid got=%0d exp=%0d", dv_count, n0); end
      exp_offset = 20;
      do_read(1020, 1'b0, 1'b1);
`else
      cali = 1'b1;
      step();
      cali = 1'b0;
      total++; if (cali_busy !== 1'b0) begin bad++; $display("FAIL cali_ignored got=%0b exp=0", cali_busy); end
      do_read(1020, 1'b0, 1'b1);
`endif
   endtask

   task automatic test_reset_mid_req();
      int n0;
      n0 = dv_count;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      reset = 1'b1;
      #2;
      total++; if (rd_req !== 1'b0)     begin bad++; $display("FAIL mid_rst_rd_req got=%0b exp=0", rd_req); end
      total++; if (data_out !== 27'd0)  begin bad++; $display("FAIL mid_rst_data got=%0h exp=0", data_out); end
      total++; if (err_cnt !== 8'd0 || ovr_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_cnts err=%0d ovr=%0d exp 0/0", err_cnt, ovr_cnt); end
      total++; if (cali_busy !== 1'b0)  begin bad++; $display("FAIL mid_rst_cali got=%0b exp=0", cali_busy); end
      step();
      reset = 1'b0;
      rd_data = 16'd1000;
      rd_done = 1'b1;
      step();
      rd_done = 1'b0;
      repeat (3) step();
      total++; if (rd_req !== 1'b0 || dv_count !== n0) begin bad++; $display("FAIL late_rd_done rd_req=%0b dv=%0d exp 0/%0d", rd_req, dv_count, n0); end
      total++; if (data_out !== 27'd0) begin bad++; $display("FAIL late_rd_done_data got=%0h exp=0", data_out); end
      exp_offset = 0;
      do_read(500, 1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_errors();
      test_overrun();
      test_back_to_back();
      test_cali();
      test_reset_mid_req();
      repeat (4) step();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL missing_valids got=%0d pending exp=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
